// File: rtl/pe_accum.sv
// Window accumulator behind the int8 dot-product PE: sums the beats of one
// first..last window in a wide accumulator and queues saturated results in a 2-entry FIFO.
module pe_accum #(
    parameter int ACC_W = 48,
    parameter int CNT_W = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ivalid,
    output logic                    oready,
    input  logic signed [31:0]      dot_accum,
    input  logic                    in_first,
    input  logic                    in_last,
    output logic                    ovalid,
    input  logic                    iready,
    output logic signed [31:0]      result,
    output logic                    sat,
    output logic [CNT_W-1:0]        beats,
    output logic                    err
);

    localparam int DATA_W = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t                    state;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_nxt;
    logic signed [ACC_W-1:0]   x_ext;
    logic [CNT_W-1:0]          cnt;
    logic [CNT_W-1:0]          cnt_nxt;
    logic                      accept;
    logic                      pop;
    logic                      drop;
    logic                      restart;
    logic                      push;
    logic signed [DATA_W-1:0]  sat_val;
    logic                      sat_flag;

    logic [1:0]                count;
    logic                      wr_ptr;
    logic                      rd_ptr;
    logic signed [DATA_W-1:0]  fifo_result [2];
    logic                      fifo_sat    [2];
    logic [CNT_W-1:0]          fifo_beats  [2];

    // Returns {clamped, value}; the sum fits when every bit from 31 upward matches the sign.
    function automatic logic [DATA_W:0] sat32(input logic signed [ACC_W-1:0] v);
        logic fits;
        fits = (&v[ACC_W-1:DATA_W-1]) | ~(|v[ACC_W-1:DATA_W-1]);
        if (fits)
            return {1'b0, v[DATA_W-1:0]};
        else if (v[ACC_W-1])
            return {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
        else
            return {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
    endfunction

    assign oready = (count != 2'd2);
    assign ovalid = (count != 2'd0);
    assign result = fifo_result[rd_ptr];
    assign sat    = fifo_sat[rd_ptr];
    assign beats  = fifo_beats[rd_ptr];

    always_comb begin
        accept  = ivalid && oready;
        pop     = ovalid && iready;
        drop    = (state == IDLE) && !in_first;
        restart = (state == ACCUM) && in_first;
        x_ext   = {{(ACC_W-DATA_W){dot_accum[DATA_W-1]}}, dot_accum};
        acc_nxt = x_ext;
        cnt_nxt = CNT_W'(1);
        if ((state == ACCUM) && !in_first) begin
            acc_nxt = acc + x_ext;
            cnt_nxt = (&cnt) ? cnt : cnt + CNT_W'(1);
        end
        push = accept && in_last && !drop;
        {sat_flag, sat_val} = sat32(acc_nxt);
    end

    // Window FSM: a dropped beat leaves acc/cnt untouched, a restart reloads them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
        end else if (accept) begin
            if (drop || restart)
                err <= 1'b1;
            if (!drop) begin
                acc   <= acc_nxt;
                cnt   <= cnt_nxt;
                state <= in_last ? IDLE : ACCUM;
            end
        end
    end

    // Result FIFO; push never meets a full FIFO because accept is gated by oready.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_result[i] <= '0;
                fifo_sat[i]    <= 1'b0;
                fifo_beats[i]  <= '0;
            end
        end else begin
            if (push) begin
                fifo_result[wr_ptr] <= sat_val;
                fifo_sat[wr_ptr]    <= sat_flag;
                fifo_beats[wr_ptr]  <= cnt_nxt;
                wr_ptr              <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
